// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_deadtime_gen
// Brief    : Splits a single-ended PWM into a complementary high/low-side pair
//            with programmable rise/fall dead times; register-bus configured.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_deadtime_gen #(
    parameter int unsigned ADDR_BASE = 0,
    parameter int unsigned BW_DT     = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    input  logic        PWM,
    output logic        PwmHS,
    output logic        PwmLS
);

    localparam logic [29:0] c_BASE_WORD = 30'(ADDR_BASE);

    typedef enum logic [2:0] {
        S_OFF = 3'd0,
        S_LO  = 3'd1,
        S_DR  = 3'd2,
        S_HI  = 3'd3,
        S_DF  = 3'd4
    } state_e;

    state_e             state_q;
    logic [BW_DT-1:0]   cnt_q;
    logic               hs_q;
    logic               ls_q;
    logic [2:0]         ctl_q;
    logic [BW_DT-1:0]   rise_q;
    logic [BW_DT-1:0]   fall_q;
    logic [15:0]        swcnt_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;

    logic [2:0]         ctl_d;
    logic [BW_DT-1:0]   rise_d;
    logic [BW_DT-1:0]   fall_d;

    logic [29:0]        w_word_off;
    logic               w_hit;
    logic [1:0]         w_sel;
    logic               w_wr;
    logic               w_rd;
    logic               w_clr;
    logic               w_swallow;
    logic               w_en;
    logic               w_hspol;
    logic               w_lspol;
    logic [31:0]        w_bmask;
    logic [31:0]        w_ctl_m;
    logic [31:0]        w_rise_m;
    logic [31:0]        w_fall_m;
    logic [31:0]        w_rd_mux;
    logic               w_unused;

    // Offset subtraction keeps the decode correct for any base, including 0.
    assign w_word_off = addr[31:2] - c_BASE_WORD;
    assign w_hit      = (w_word_off[29:2] == 28'd0);
    assign w_sel      = w_word_off[1:0];
    assign gnt        = req & w_hit;
    assign w_wr       = gnt & we;
    assign w_rd       = gnt & ~we;
    assign w_clr      = w_wr & (w_sel == 2'd3);

    assign w_en    = ctl_q[0];
    assign w_hspol = ctl_q[1];
    assign w_lspol = ctl_q[2];

    assign w_bmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign w_ctl_m  = (32'(ctl_q)  & ~w_bmask) | (wdata & w_bmask);
    assign w_rise_m = (32'(rise_q) & ~w_bmask) | (wdata & w_bmask);
    assign w_fall_m = (32'(fall_q) & ~w_bmask) | (wdata & w_bmask);

    assign ctl_d  = (w_wr && w_sel == 2'd0) ? w_ctl_m[2:0]        : ctl_q;
    assign rise_d = (w_wr && w_sel == 2'd1) ? w_rise_m[BW_DT-1:0] : rise_q;
    assign fall_d = (w_wr && w_sel == 2'd2) ? w_fall_m[BW_DT-1:0] : fall_q;

    assign w_unused = ^{addr[1:0], w_ctl_m, w_rise_m, w_fall_m};

    // A swallow is a dead-time window aborted because PWM reverted.
    assign w_swallow = w_en & (((state_q == S_DR) & ~PWM) | ((state_q == S_DF) & PWM));

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_sel)
            2'd0:    w_rd_mux = {29'd0, ctl_q};
            2'd1:    w_rd_mux = 32'(rise_q);
            2'd2:    w_rd_mux = 32'(fall_q);
            default: w_rd_mux = {13'd0, state_q, swcnt_q};
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctl_q    <= 3'd0;
            rise_q   <= '0;
            fall_q   <= '0;
            swcnt_q  <= 16'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            ctl_q    <= ctl_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            rvalid_q <= w_rd;
            rdata_q  <= w_rd ? w_rd_mux : 32'd0;
            if (w_clr) begin
                swcnt_q <= 16'd0;
            end else if (w_swallow && swcnt_q != 16'hFFFF) begin
                swcnt_q <= swcnt_q + 16'd1;
            end
        end
    end

    // Outputs follow the registered state, so each side changes one cycle after
    // the state does; this is what guarantees the 1-cycle minimum gap.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            hs_q    <= 1'b1;
            ls_q    <= 1'b1;
        end else begin
            hs_q <= (w_en && state_q == S_HI) ? w_hspol : ~w_hspol;
            ls_q <= (w_en && state_q == S_LO) ? w_lspol : ~w_lspol;
            if (!w_en) begin
                state_q <= S_OFF;
            end else begin
                case (state_q)
                    S_OFF: begin
                        if (PWM) begin
                            state_q <= S_DR;
                            cnt_q   <= rise_q;
                        end else begin
                            state_q <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (PWM) begin
                            state_q <= S_DR;
                            cnt_q   <= rise_q;
                        end
                    end
                    S_DR: begin
                        if (!PWM) begin
                            state_q <= S_LO;
                        end else if (cnt_q == '0) begin
                            state_q <= S_HI;
                        end else begin
                            cnt_q <= cnt_q - BW_DT'(1);
                        end
                    end
                    S_HI: begin
                        if (!PWM) begin
                            state_q <= S_DF;
                            cnt_q   <= fall_q;
                        end
                    end
                    S_DF: begin
                        if (PWM) begin
                            state_q <= S_HI;
                        end else if (cnt_q == '0) begin
                            state_q <= S_LO;
                        end else begin
                            cnt_q <= cnt_q - BW_DT'(1);
                        end
                    end
                    default: state_q <= S_OFF;
                endcase
            end
        end
    end

    assign PwmHS  = hs_q;
    assign PwmLS  = ls_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_deadtime_gen
// Brief    : Randomized bench for pwm_deadtime_gen against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_deadtime_gen;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        PWM = 1'b0;
    logic        PwmHS;
    logic        PwmLS;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: registers plus a run-length view of the dead-time engine.
    logic [2:0]  m_ctl;
    logic [7:0]  m_rise;
    logic [7:0]  m_fall;
    logic [15:0] m_cnt;
    logic        m_off;
    logic        m_side;
    int          m_run;
    int          m_dlat;
    logic        exp_hs;
    logic        exp_ls;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;

    pwm_deadtime_gen dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .be     (be),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .PWM    (PWM),
        .PwmHS  (PwmHS),
        .PwmLS  (PwmLS)
    );

    initial forever #5 Clk = ~Clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctl = 3'd0; m_rise = 8'd0; m_fall = 8'd0; m_cnt = 16'd0;
        m_off = 1'b1; m_side = 1'b0; m_run = 0; m_dlat = 0;
        exp_rvalid = 1'b0; exp_rdata = 32'd0;
    endtask

    function automatic logic [2:0] m_state();
        if (m_off)       return 3'd0;
        if (m_run == 0)  return m_side ? 3'd3 : 3'd1;
        return m_side ? 3'd4 : 3'd2;
    endfunction

    // A side change completes once PWM has disagreed with the settled side for
    // dead-time+2 consecutive samples; an earlier agreement is a swallow.
    task automatic model_edge(input logic g, input logic w, input logic [1:0] off,
                              input logic [3:0] b, input logic [31:0] d, input logic p);
        logic en;
        logic swallow;
        en = m_ctl[0];
        exp_hs = (en && !m_off && m_side && m_run == 0)  ? m_ctl[1] : ~m_ctl[1];
        exp_ls = (en && !m_off && !m_side && m_run == 0) ? m_ctl[2] : ~m_ctl[2];
        exp_rvalid = g && !w;
        exp_rdata  = 32'd0;
        if (g && !w) begin
            case (off)
                2'd0:    exp_rdata = {29'd0, m_ctl};
                2'd1:    exp_rdata = {24'd0, m_rise};
                2'd2:    exp_rdata = {24'd0, m_fall};
                default: exp_rdata = {13'd0, m_state(), m_cnt};
            endcase
        end
        swallow = 1'b0;
        if (!en) begin
            m_off = 1'b1;
            m_run = 0;
        end else begin
            if (m_off) begin
                m_off = 1'b0; m_side = 1'b0; m_run = 0;
            end
            if (p != m_side) begin
                if (m_run == 0) m_dlat = m_side ? int'(m_fall) : int'(m_rise);
                m_run++;
                if (m_run == m_dlat + 2) begin
                    m_side = ~m_side;
                    m_run  = 0;
                end
            end else if (m_run > 0) begin
                swallow = 1'b1;
                m_run   = 0;
            end
        end
        if (g && w && off == 2'd3)              m_cnt = 16'd0;
        else if (swallow && m_cnt != 16'hFFFF)  m_cnt = m_cnt + 16'd1;
        if (g && w && b[0]) begin
            case (off)
                2'd0:    m_ctl  = d[2:0];
                2'd1:    m_rise = d[7:0];
                2'd2:    m_fall = d[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input logic p);
        logic g;
        @(negedge Clk);
        req = r; we = w; addr = a; be = b; wdata = d; PWM = p;
        g = r && (a[31:4] == 28'd0);
        #1;
        chk_eq("gnt", 32'(gnt), 32'(g));
        @(posedge Clk);
        model_edge(g, w, a[3:2], b, d, p);
        #1;
        chk_eq("pwm_hs", 32'(PwmHS), 32'(exp_hs));
        chk_eq("pwm_ls", 32'(PwmLS), 32'(exp_ls));
        chk_eq("rvalid", 32'(rvalid), 32'(exp_rvalid));
        chk_eq("rdata", rdata, exp_rdata);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic p);
        cycle(1'b1, 1'b1, {28'd0, r, 2'b00}, 4'hF, d, p);
    endtask

    task automatic rd(input logic [1:0] r, input logic p);
        cycle(1'b1, 1'b0, {28'd0, r, 2'b00}, 4'h0, 32'd0, p);
    endtask

    task automatic idle(input logic p);
        cycle(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, p);
    endtask

    initial begin
        int hs_rise;
        int ls_rise;
        logic hs_prev;
        logic ls_prev;
        logic p;
        logic rp;
        int run_left;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0] word;

        model_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk_eq("rst_hs", 32'(PwmHS), 32'd1);
        chk_eq("rst_ls", 32'(PwmLS), 32'd1);
        chk_eq("rst_rvalid", 32'(rvalid), 32'd0);
        chk_eq("rst_rdata", rdata, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) rd(2'(i), 1'b0);

        // Square wave with rise 4 / fall 2
        wr(2'd1, 32'd4, 1'b0);
        wr(2'd2, 32'd2, 1'b0);
        wr(2'd0, 32'd7, 1'b0);
        hs_rise = -1; ls_rise = -1;
        hs_prev = PwmHS; ls_prev = PwmLS;
        for (int i = 0; i < 160; i++) begin
            p = ((i / 40) % 2) == 1;
            idle(p);
            chk_eq("no_overlap", 32'(PwmHS & PwmLS), 32'd0);
            if (PwmHS && !hs_prev && hs_rise < 0) hs_rise = i;
            if (PwmLS && !ls_prev && i > 80 && ls_rise < 0) ls_rise = i;
            hs_prev = PwmHS; ls_prev = PwmLS;
        end
        chk_eq("hs_rise_lat", 32'(hs_rise - 40), 32'd6);
        chk_eq("ls_rise_lat", 32'(ls_rise - 80), 32'd4);

        // Short pulse inside a long rise dead time is swallowed
        wr(2'd1, 32'd10, 1'b0);
        repeat (10) idle(1'b0);
        repeat (3) begin
            idle(1'b1);
            chk_eq("swallow_hs", 32'(PwmHS), 32'd0);
        end
        repeat (20) begin
            idle(1'b0);
            chk_eq("swallow_hs", 32'(PwmHS), 32'd0);
        end
        chk_eq("swallow_ls", 32'(PwmLS), 32'd1);
        rd(2'd3, 1'b0);
        chk_eq("swallow_cnt", 32'(rdata[15:0]), 32'd1);
        wr(2'd3, 32'd0, 1'b0);
        rd(2'd3, 1'b0);
        chk_eq("swallow_clr", 32'(rdata[15:0]), 32'd0);

        // Disable while high, then re-enable with PWM already high
        repeat (20) idle(1'b1);
        wr(2'd0, 32'd6, 1'b1);
        idle(1'b1);
        chk_eq("dis_hs", 32'(PwmHS), 32'd0);
        chk_eq("dis_ls", 32'(PwmLS), 32'd0);
        rd(2'd3, 1'b1);
        chk_eq("dis_state", 32'(rdata[18:16]), 32'd0);
        wr(2'd0, 32'd7, 1'b1);
        hs_rise = -1;
        for (int j = 0; j < 20; j++) begin
            idle(1'b1);
            if (PwmHS && hs_rise < 0) hs_rise = j;
        end
        chk_eq("reen_hs_lat", 32'(hs_rise), 32'd12);

        // Asynchronous reset in the middle of a rise dead time
        repeat (6) idle(1'b0);
        repeat (3) idle(1'b1);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk_eq("arst_hs", 32'(PwmHS), 32'd1);
        chk_eq("arst_ls", 32'(PwmLS), 32'd1);
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) rd(2'(i), 1'b0);

        // Out-of-range accesses and empty byte enables
        wr(2'd1, 32'd5, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'd9, 1'b0);
        cycle(1'b1, 1'b0, 32'h0000_0014, 4'hF, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 32'h8000_0004, 4'hF, 32'd9, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0000, 4'h0, 32'd7, 1'b0);
        for (int i = 0; i < 4; i++) rd(2'(i), 1'b0);

        // Randomized traffic
        wr(2'd1, 32'd3, 1'b0);
        wr(2'd2, 32'd1, 1'b0);
        wr(2'd0, 32'd1, 1'b0);
        rp = 1'b0;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                rp = ~rp;
                run_left = $urandom_range(1, 14);
            end
            run_left--;
            word = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = {27'd0, word, 2'($urandom_range(0, 3))};
            if (a[3:2] == 2'd0) begin
                d = $urandom();
                if ($urandom_range(0, 9) != 0) d[0] = 1'b1;
            end else begin
                d = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
            end
            cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a,
                  4'($urandom_range(0, 15)), d, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
